// File: rtl/ntt_bfly_pipe.sv
// ntt_bfly_pipe
// -----------------------------------------------------------------------------
// Fully pipelined radix-2 NTT butterfly over the prime modulus Q. Each
// transaction selects either a Cooley-Tukey forward butterfly or a
// Gentleman-Sande inverse butterfly. The inverse butterfly can optionally
// halve both results, which is the 1/N scaling step of the inverse transform.
//
// Modes:
//   CT : t = w*y mod Q;   x' = x + t;   y' = x - t
//   GS : x' = x + y;      y' = (x - y) * w
//   GS with halve : each result a becomes a * 2^-1 mod Q
// All results are fully reduced to [0, Q).
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational from
//                         out_valid and out_ready only)
//   in_mode               0 = CT, 1 = GS
//   in_halve              GS only: scale both outputs by 2^-1 mod Q
//   in_x, in_y, in_w      coefficients and twiddle, each in [0, Q)
//   in_tag                sideband, returned unchanged with the result
//   out_valid / out_ready output handshake
//   out_x, out_y          results in [0, Q)
//   out_tag               tag of the transaction being presented
//
// Pipeline (one register bank per stage, the whole pipe advances together):
//   s0 capture inputs
//   s1 GS pre-add/sub, or CT operand routing
//   s2 W x W multiply
//   s3 Barrett quotient estimate
//   s4 remainder estimate (< 3Q)
//   s5 final correction to [0, Q)
//   s6 CT add/sub or GS halving into the output registers
// An input accepted at edge n is in the output registers after edge n+6.
// The arithmetic stage count is fixed, so LAT must stay at 6.
// -----------------------------------------------------------------------------
module ntt_bfly_pipe #(
    parameter int W    = 14,
    parameter int Q    = 12289,
    parameter int TAGW = 8,
    parameter int LAT  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic            in_halve,
    input  logic [W-1:0]    in_x,
    input  logic [W-1:0]    in_y,
    input  logic [W-1:0]    in_w,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_x,
    output logic [W-1:0]    out_y,
    output logic [TAGW-1:0] out_tag
);

    // floor(2^(2W) / Q) computed by restoring long division, so no divide
    // operator is needed even at elaboration time.
    function automatic logic [W:0] calc_mu();
        logic [2*W+1:0] rem;
        logic [W:0]     quo;
        rem = '0;
        quo = '0;
        for (int i = 2 * W; i >= 0; i--) begin
            rem = (rem << 1) | (2*W+2)'(i == 2 * W);
            quo = quo << 1;
            if (rem >= (2*W+2)'(Q)) begin
                rem    = rem - (2*W+2)'(Q);
                quo[0] = 1'b1;
            end
        end
        return quo;
    endfunction

    localparam logic [W:0]   MU    = calc_mu();
    localparam logic [W:0]   Q_W1  = (W+1)'(Q);
    localparam logic [W+1:0] Q_W2  = (W+2)'(Q);
    localparam logic [W+1:0] Q2_W2 = (W+2)'(2 * Q);

    // (a + b) mod Q for a, b in [0, Q)
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_W1) begin
            s = s - Q_W1;
        end
        return W'(s);
    endfunction

    // (a - b) mod Q for a, b in [0, Q); bit W of the difference is the borrow
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) begin
            d = d + Q_W1;
        end
        return W'(d);
    endfunction

    // a * 2^-1 mod Q: Q is odd, so an odd a becomes even after adding Q
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] a);
        logic [W:0] s;
        s = a[0] ? ({1'b0, a} + Q_W1) : {1'b0, a};
        return W'(s >> 1);
    endfunction

    // ---------------------------------------------------------------------
    // Control: per-stage valid bits, mode/halve and tag follow the data.
    // Index k holds the control of the data currently in stage k.
    // ---------------------------------------------------------------------
    logic [LAT:0]    vld_q,   vld_d;
    logic [LAT-1:0]  mode_q,  mode_d;
    logic [LAT-1:0]  halve_q, halve_d;
    logic [TAGW-1:0] tag_q [LAT+1];
    logic [TAGW-1:0] tag_d [LAT+1];

    // Datapath registers
    logic [W-1:0]   x0_q, x0_d, y0_q, y0_d, w0_q, w0_d;
    logic [W-1:0]   a1_q, a1_d, m1_q, m1_d, w1_q, w1_d;
    logic [W-1:0]   a2_q, a2_d;
    logic [2*W-1:0] p2_q, p2_d;
    logic [W-1:0]   a3_q, a3_d, qe3_q, qe3_d;
    logic [2*W-1:0] p3_q, p3_d;
    logic [W-1:0]   a4_q, a4_d;
    logic [W+1:0]   r4_q, r4_d;
    logic [W-1:0]   a5_q, a5_d, t5_q, t5_d;
    logic [W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;

    logic adv;

    // A stall anywhere is a stall everywhere: only the output can refuse.
    assign adv      = !vld_q[LAT] || out_ready;
    assign in_ready = adv;

    assign out_valid = vld_q[LAT];
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_tag   = tag_q[LAT];

    // ---------------------------------------------------------------------
    // Combinational arithmetic feeding each register stage
    // ---------------------------------------------------------------------
    logic [W-1:0]   s1_a, s1_m;
    logic [2*W-1:0] s2_prod;
    logic [3*W:0]   s3_barrett;
    logic [2*W-1:0] s4_qq;
    logic [W+1:0]   s5_fix;
    logic [W-1:0]   s6_x, s6_y;

    always_comb begin
        // s1: GS folds x+y / x-y ahead of the multiplier; CT multiplies y
        if (mode_q[0]) begin
            s1_a = add_mod(x0_q, y0_q);
            s1_m = sub_mod(x0_q, y0_q);
        end else begin
            s1_a = x0_q;
            s1_m = y0_q;
        end

        s2_prod = (2*W)'(m1_q) * (2*W)'(w1_q);

        // Quotient estimate floor(p * MU / 2^(2W)) never exceeds the true
        // quotient and falls short of it by at most 2.
        s3_barrett = (3*W+1)'(p2_q) * (3*W+1)'(MU);

        // Remainder estimate is below 3Q, so W+2 bits hold it exactly.
        s4_qq = (2*W)'(qe3_q) * (2*W)'(Q);

        if (r4_q >= Q2_W2) begin
            s5_fix = r4_q - Q2_W2;
        end else if (r4_q >= Q_W2) begin
            s5_fix = r4_q - Q_W2;
        end else begin
            s5_fix = r4_q;
        end

        // s6: in CT, a5 is x and t5 is w*y; in GS, a5 is x+y and t5 is (x-y)*w
        if (mode_q[LAT-1]) begin
            if (halve_q[LAT-1]) begin
                s6_x = half_mod(a5_q);
                s6_y = half_mod(t5_q);
            end else begin
                s6_x = a5_q;
                s6_y = t5_q;
            end
        end else begin
            s6_x = add_mod(a5_q, t5_q);
            s6_y = sub_mod(a5_q, t5_q);
        end
    end

    // ---------------------------------------------------------------------
    // Next-state: hold everything unless the pipe advances; data registers
    // only load when the slot behind them carries a real transaction.
    // ---------------------------------------------------------------------
    always_comb begin
        vld_d   = vld_q;
        mode_d  = mode_q;
        halve_d = halve_q;
        tag_d   = tag_q;
        x0_d = x0_q;  y0_d = y0_q;  w0_d = w0_q;
        a1_d = a1_q;  m1_d = m1_q;  w1_d = w1_q;
        a2_d = a2_q;  p2_d = p2_q;
        a3_d = a3_q;  p3_d = p3_q;  qe3_d = qe3_q;
        a4_d = a4_q;  r4_d = r4_q;
        a5_d = a5_q;  t5_d = t5_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;

        if (adv) begin
            vld_d = {vld_q[LAT-1:0], in_valid};

            if (in_valid) begin
                x0_d       = in_x;
                y0_d       = in_y;
                w0_d       = in_w;
                mode_d[0]  = in_mode;
                halve_d[0] = in_halve;
                tag_d[0]   = in_tag;
            end

            for (int k = 1; k <= LAT; k++) begin
                if (vld_q[k-1]) begin
                    tag_d[k] = tag_q[k-1];
                    if (k < LAT) begin
                        mode_d[k]  = mode_q[k-1];
                        halve_d[k] = halve_q[k-1];
                    end
                end
            end

            if (vld_q[0]) begin
                a1_d = s1_a;
                m1_d = s1_m;
                w1_d = w0_q;
            end
            if (vld_q[1]) begin
                a2_d = a1_q;
                p2_d = s2_prod;
            end
            if (vld_q[2]) begin
                a3_d  = a2_q;
                p3_d  = p2_q;
                qe3_d = W'(s3_barrett >> (2 * W));
            end
            if (vld_q[3]) begin
                a4_d = a3_q;
                r4_d = (W+2)'(p3_q - s4_qq);
            end
            if (vld_q[4]) begin
                a5_d = a4_q;
                t5_d = W'(s5_fix);
            end
            if (vld_q[5]) begin
                out_x_d = s6_x;
                out_y_d = s6_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            mode_q  <= '0;
            halve_q <= '0;
            tag_q   <= '{default: '0};
            x0_q <= '0;  y0_q <= '0;  w0_q <= '0;
            a1_q <= '0;  m1_q <= '0;  w1_q <= '0;
            a2_q <= '0;  p2_q <= '0;
            a3_q <= '0;  p3_q <= '0;  qe3_q <= '0;
            a4_q <= '0;  r4_q <= '0;
            a5_q <= '0;  t5_q <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
        end else begin
            vld_q   <= vld_d;
            mode_q  <= mode_d;
            halve_q <= halve_d;
            tag_q   <= tag_d;
            x0_q <= x0_d;  y0_q <= y0_d;  w0_q <= w0_d;
            a1_q <= a1_d;  m1_q <= m1_d;  w1_q <= w1_d;
            a2_q <= a2_d;  p2_q <= p2_d;
            a3_q <= a3_d;  p3_q <= p3_d;  qe3_q <= qe3_d;
            a4_q <= a4_d;  r4_q <= r4_d;
            a5_q <= a5_d;  t5_q <= t5_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
        end
    end

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// tb_ntt_bfly_pipe
// -----------------------------------------------------------------------------
// Directed and streaming checks for ntt_bfly_pipe. Inputs are driven and
// outputs sampled on the falling clock edge. Each transaction check prints
// one line on failure only; a single summary line closes the run.
// -----------------------------------------------------------------------------
module tb_ntt_bfly_pipe;

    localparam int W    = 14;
    localparam int Q    = 12289;
    localparam int TAGW = 8;
    localparam int LAT  = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic            in_halve;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic [W-1:0]    in_w;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_x;
    logic [W-1:0]    out_y;
    logic [TAGW-1:0] out_tag;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        int tag;
        int cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ntt_bfly_pipe #(.W(W), .Q(Q), .TAGW(TAGW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_halve  (in_halve),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_tag   (out_tag)
    );

    // Golden butterfly, written directly from the modular definitions.
    function automatic int hmod(input int a);
        return (a % 2 == 0) ? a / 2 : (a + Q) / 2;
    endfunction

    function automatic void model(input int x, input int y, input int w, input int mode,
                                  input int halve, output int ox, output int oy);
        longint t;
        if (mode == 0) begin
            t  = (longint'(w) * longint'(y)) % Q;
            ox = int'((longint'(x) + t) % Q);
            oy = int'((longint'(x) - t + Q) % Q);
        end else begin
            ox = (x + y) % Q;
            oy = int'((longint'((x - y + Q) % Q) * longint'(w)) % Q);
            if (halve != 0) begin
                ox = hmod(ox);
                oy = hmod(oy);
            end
        end
    endfunction

    // Drives one transaction into an empty pipe with out_ready high and
    // returns the first result seen plus the number of edges it took.
    task automatic send_one(input int x, input int y, input int w, input int mode,
                            input int halve, input int tag,
                            output logic [W-1:0] ox, output logic [W-1:0] oy,
                            output logic [TAGW-1:0] otag, output int lat);
        lat  = -1;
        ox   = '0;
        oy   = '0;
        otag = '0;
        @(negedge clk);
        in_x      = W'(x);
        in_y      = W'(y);
        in_w      = W'(w);
        in_mode   = mode[0];
        in_halve  = halve[0];
        in_tag    = TAGW'(tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat  = n - 1;
                ox   = out_x;
                oy   = out_y;
                otag = out_tag;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mode   = 1'b0;
        in_halve  = 1'b0;
        in_x = '0; in_y = '0; in_w = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_x !== '0) begin miscompares++; $display("FAIL reset_out_x: got %0d expected 0", out_x); end
        vectors++;
        if (out_y !== '0) begin miscompares++; $display("FAIL reset_out_y: got %0d expected 0", out_y); end
        vectors++;
        if (out_tag !== '0) begin miscompares++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_ct_basic();
        logic [W-1:0] ox, oy;
        logic [TAGW-1:0] ot;
        int lat;
        send_one(5, 3, 2, 0, 0, 'h11, ox, oy, ot, lat);
        vectors++;
        if (ox !== 11) begin miscompares++; $display("FAIL ct_basic_x: got %0d expected 11", ox); end
        vectors++;
        if (oy !== 12288) begin miscompares++; $display("FAIL ct_basic_y: got %0d expected 12288", oy); end
        vectors++;
        if (ot !== 8'h11) begin miscompares++; $display("FAIL ct_basic_tag: got %0h expected 11", ot); end
        vectors++;
        if (lat != 6) begin miscompares++; $display("FAIL ct_basic_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_ct_extreme();
        logic [W-1:0] ox, oy;
        logic [TAGW-1:0] ot;
        int lat;
        // (Q-1)^2 product: t = 1, x + t = Q wraps to 0
        send_one(12288, 12288, 12288, 0, 0, 'h22, ox, oy, ot, lat);
        vectors++;
        if (ox !== 0) begin miscompares++; $display("FAIL ct_extreme_x: got %0d expected 0", ox); end
        vectors++;
        if (oy !== 12287) begin miscompares++; $display("FAIL ct_extreme_y: got %0d expected 12287", oy); end
        // x = t = 6 gives y' = 0
        send_one(6, 3, 2, 0, 0, 'h23, ox, oy, ot, lat);
        vectors++;
        if (ox !== 12) begin miscompares++; $display("FAIL ct_x_eq_t_x: got %0d expected 12", ox); end
        vectors++;
        if (oy !== 0) begin miscompares++; $display("FAIL ct_x_eq_t_y: got %0d expected 0", oy); end
        // halve has no effect in CT mode
        send_one(5, 3, 2, 0, 1, 'h24, ox, oy, ot, lat);
        vectors++;
        if (ox !== 11 || oy !== 12288) begin
            miscompares++; $display("FAIL ct_halve_ignored: got %0d/%0d expected 11/12288", ox, oy);
        end
    endtask

    task automatic test_gs();
        logic [W-1:0] ox, oy;
        logic [TAGW-1:0] ot;
        int lat;
        send_one(5, 3, 2, 1, 0, 'h31, ox, oy, ot, lat);
        vectors++;
        if (ox !== 8) begin miscompares++; $display("FAIL gs_x: got %0d expected 8", ox); end
        vectors++;
        if (oy !== 4) begin miscompares++; $display("FAIL gs_y: got %0d expected 4", oy); end
        vectors++;
        if (lat != 6) begin miscompares++; $display("FAIL gs_latency: got %0d expected 6", lat); end
        send_one(5, 3, 2, 1, 1, 'h32, ox, oy, ot, lat);
        vectors++;
        if (ox !== 4) begin miscompares++; $display("FAIL gs_halve_x: got %0d expected 4", ox); end
        vectors++;
        if (oy !== 2) begin miscompares++; $display("FAIL gs_halve_y: got %0d expected 2", oy); end
        send_one(1, 0, 1, 1, 1, 'h33, ox, oy, ot, lat);
        vectors++;
        if (ox !== 6145) begin miscompares++; $display("FAIL gs_halve_odd_x: got %0d expected 6145", ox); end
        vectors++;
        if (oy !== 6145) begin miscompares++; $display("FAIL gs_halve_odd_y: got %0d expected 6145", oy); end
        vectors++;
        if (ot !== 8'h33) begin miscompares++; $display("FAIL gs_tag: got %0h expected 33", ot); end
    endtask

    // 200 back-to-back transactions with mixed modes and out_ready high.
    // Acceptance is decided at falling edge k and the result shows at falling
    // edge k+LAT+1 (accept edge plus LAT further rising edges).
    task automatic test_back_to_back();
        int sent = 0;
        int cyc  = 0;
        int x, y, w, m, h, ex, ey;
        exp_t e;
        sb.delete();
        while ((sent < 200 || sb.size() != 0) && cyc < 600) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 200) begin
                x = int'($urandom_range(Q - 1, 0));
                y = int'($urandom_range(Q - 1, 0));
                w = int'($urandom_range(Q - 1, 0));
                m = int'($urandom_range(1, 0));
                h = int'($urandom_range(1, 0));
                in_x = W'(x); in_y = W'(y); in_w = W'(w);
                in_mode = m[0]; in_halve = h[0]; in_tag = TAGW'(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready: got %b expected 1", in_ready); end
            if (out_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL stream_extra_output: got tag %0d expected none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_x !== W'(e.x) || out_y !== W'(e.y) || out_tag !== TAGW'(e.tag) || cyc - e.cyc != LAT + 1) begin
                        miscompares++;
                        $display("FAIL stream_result: got x=%0d y=%0d tag=%0d lat=%0d expected x=%0d y=%0d tag=%0d lat=%0d",
                                 out_x, out_y, out_tag, cyc - e.cyc - 1, e.x, e.y, e.tag & 255, LAT);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(x, y, w, m, h, ex, ey);
                sb.push_back('{ex, ey, sent, cyc});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sent != 200 || sb.size() != 0) begin
            miscompares++; $display("FAIL stream_drain: got sent=%0d pending=%0d expected 200/0", sent, sb.size());
        end
    endtask

    // Random out_ready (about 30% low) and gappy input: no loss or
    // duplication, outputs held steady while stalled, in_ready tracks adv.
    task automatic test_backpressure();
        int sent = 0;
        int cyc  = 0;
        int x, y, w, m, h, ex, ey;
        logic hold = 1'b0;
        logic [W-1:0] hx, hy;
        logic [TAGW-1:0] ht;
        exp_t e;
        sb.delete();
        while ((sent < 150 || sb.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy || out_tag !== ht) begin
                    miscompares++;
                    $display("FAIL bp_stall_stable: got v=%b x=%0d y=%0d tag=%0d expected v=1 x=%0d y=%0d tag=%0d",
                             out_valid, out_x, out_y, out_tag, hx, hy, ht);
                end
            end
            out_ready = ($urandom_range(99, 0) >= 30);
            if (sent < 150 && $urandom_range(99, 0) < 85) begin
                x = int'($urandom_range(Q - 1, 0));
                y = int'($urandom_range(Q - 1, 0));
                w = int'($urandom_range(Q - 1, 0));
                m = int'($urandom_range(1, 0));
                h = int'($urandom_range(1, 0));
                in_x = W'(x); in_y = W'(y); in_w = W'(w);
                in_mode = m[0]; in_halve = h[0]; in_tag = TAGW'(sent + 64);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                miscompares++; $display("FAIL bp_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra_output: got tag %0d expected none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_x !== W'(e.x) || out_y !== W'(e.y) || out_tag !== TAGW'(e.tag)) begin
                        miscompares++;
                        $display("FAIL bp_result: got x=%0d y=%0d tag=%0d expected x=%0d y=%0d tag=%0d",
                                 out_x, out_y, out_tag, e.x, e.y, e.tag & 255);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(x, y, w, m, h, ex, ey);
                sb.push_back('{ex, ey, sent + 64, cyc});
                sent++;
            end
            hold = out_valid && !out_ready;
            hx = out_x; hy = out_y; ht = out_tag;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (sent != 150 || sb.size() != 0) begin
            miscompares++; $display("FAIL bp_drain: got sent=%0d pending=%0d expected 150/0", sent, sb.size());
        end
    endtask

    // Reset with the output register full and several transactions behind it.
    task automatic test_reset_midstream();
        logic [W-1:0] ox, oy;
        logic [TAGW-1:0] ot;
        int lat;
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_x = W'(100 + i); in_y = W'(7 * i); in_w = W'(3 + i);
            in_mode = i[0]; in_halve = 1'b0; in_tag = TAGW'(8'hA0 + i);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_x !== '0 || out_y !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_async_clear: got v=%b x=%0d y=%0d tag=%0d expected all 0", out_valid, out_x, out_y, out_tag);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_x !== '0 || out_y !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_held: got v=%b x=%0d y=%0d tag=%0d expected all 0", out_valid, out_x, out_y, out_tag);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        vectors++;
        if (stale != 0) begin miscompares++; $display("FAIL rst_mid_stale: got %0d valid cycles expected 0", stale); end
        // t = 300*200 mod Q = 10844; x' = 10944; y' = 100 - 10844 + Q = 1545
        send_one(100, 200, 300, 0, 0, 'h5A, ox, oy, ot, lat);
        vectors++;
        if (ox !== 10944 || oy !== 1545 || ot !== 8'h5A) begin
            miscompares++;
            $display("FAIL rst_mid_after: got x=%0d y=%0d tag=%0h expected x=10944 y=1545 tag=5a", ox, oy, ot);
        end
        vectors++;
        if (lat != 6) begin miscompares++; $display("FAIL rst_mid_latency: got %0d expected 6", lat); end
    endtask

    initial begin
        test_reset();
        test_ct_basic();
        test_ct_extreme();
        test_gs();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
